// File: rtl/chip8_pkg.sv
// ----------------------------------------------------------------------------
// chip8_pkg
// Shared definitions for the CHIP-8 keypad scanner:
//   KP_ROWS / KP_COLS  - physical matrix geometry
//   KEY_MAP            - CHIP-8 key code for each physical position (row*4+col)
//   scan_state_t       - row scan FSM states
//   lowest_key()       - index of the lowest set bit of a 16-bit key vector
// ----------------------------------------------------------------------------
package chip8_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    // Physical layout, rows top to bottom:
    //   1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        SAMPLE = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

    // Scanning from the top down leaves the lowest set index as the result.
    function automatic logic [3:0] lowest_key(input logic [15:0] keys);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (keys[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// ----------------------------------------------------------------------------
// keypad_sync
// Two-flop synchronizer for the asynchronous keypad column inputs.
// Resets to all-ones, which is the idle (no key closed) column level.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   async  : raw column inputs
//   synced : synchronized column inputs
// ----------------------------------------------------------------------------
module keypad_sync
    import chip8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KP_COLS-1:0]   async,
    output logic [KP_COLS-1:0]   synced
);

    logic [KP_COLS-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '1;
            synced <= '1;
        end else begin
            meta   <= async;
            synced <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// ----------------------------------------------------------------------------
// keypad_scan
// Scans a 4x4 CHIP-8 hex keypad one row at a time, synchronizes and debounces
// the column readings, remaps physical positions to CHIP-8 key codes, and
// reports the held-key vector plus a one-cycle press event.
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   row_out       : row drive, active low, at most one bit low
//   col_in        : column sense, pulled up, low = key closed in driven row
//   keypad_matrix : debounced key levels indexed by CHIP-8 code, 1 = held
//   key_event     : one-cycle pulse when at least one key becomes newly held
//   key_code      : lowest newly held key code, held until the next event
// Parameters:
//   SCAN_DIV       : settle cycles per row before sampling (>= 3)
//   DEBOUNCE_SCANS : extra identical frames required before committing (>= 1)
// ----------------------------------------------------------------------------
module keypad_scan
    import chip8_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    output logic [15:0] keypad_matrix,
    output logic        key_event,
    output logic [3:0]  key_code
);

    if (SCAN_DIV < 3) begin : g_bad_scan_div
        $error("keypad_scan: SCAN_DIV must be >= 3 to cover the synchronizer");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("keypad_scan: DEBOUNCE_SCANS must be >= 1");
    end

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STABLE_MAX  = STB_W'(DEBOUNCE_SCANS);
    localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(DEBOUNCE_SCANS - 1);
    localparam logic [1:0]       ROW_LAST    = 2'(KP_ROWS - 1);

    scan_state_t      state, state_next;
    logic [1:0]       row;
    logic [DIV_W-1:0] div;
    logic [15:0]      raw;
    logic [15:0]      last;
    logic [STB_W-1:0] stable;
    logic [3:0]       col_s;
    logic [15:0]      mapped;
    logic [15:0]      newp;

    keypad_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async  (col_in),
        .synced (col_s)
    );

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        // No row is driven while reset is asserted, so the pins idle high
        // even though the state registers already point at row 0.
        row_out = 4'hF;
        case (state)
            SETTLE: begin
                if (rst_n) begin
                    row_out = ~(4'b0001 << row);
                end
                if (div == DIV_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (rst_n) begin
                    row_out = ~(4'b0001 << row);
                end
                state_next = (row == ROW_LAST) ? COMMIT : SETTLE;
            end
            COMMIT: begin
                state_next = SETTLE;
            end
            default: begin
                state_next = SETTLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Row / divider counters and raw frame capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= 2'd0;
            div <= '0;
            raw <= '0;
        end else begin
            case (state)
                SETTLE: begin
                    div <= (div == DIV_LAST) ? '0 : div + 1'b1;
                end
                SAMPLE: begin
                    div <= '0;
                    raw[{row, 2'b00} +: 4] <= ~col_s;
                    if (row != ROW_LAST) begin
                        row <= row + 2'd1;
                    end
                end
                COMMIT: begin
                    div <= '0;
                    row <= 2'd0;
                end
                default: begin
                    div <= '0;
                    row <= 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Physical -> CHIP-8 remap
    // ------------------------------------------------------------------
    always_comb begin
        mapped = '0;
        for (int p = 0; p < KP_ROWS * KP_COLS; p++) begin
            mapped[KEY_MAP[p]] = raw[p];
        end
    end

    assign newp = mapped & ~keypad_matrix;

    // ------------------------------------------------------------------
    // Debounce, commit and press event
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last          <= '0;
            stable        <= '0;
            keypad_matrix <= '0;
            key_event     <= 1'b0;
            key_code      <= 4'h0;
        end else begin
            key_event <= 1'b0;
            if (state == COMMIT) begin
                if (mapped != last) begin
                    last   <= mapped;
                    stable <= '0;
                end else if (stable < STABLE_MAX) begin
                    stable <= stable + 1'b1;
                    // Commit exactly once, on the increment that reaches the
                    // threshold; a saturated counter never recommits.
                    if (stable == STABLE_LAST) begin
                        keypad_matrix <= mapped;
                        if (newp != '0) begin
                            key_event <= 1'b1;
                            key_code  <= lowest_key(newp);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [15:0] keypad_matrix;
    logic        key_event;
    logic [3:0]  key_code;

    // Closed switches by physical position row*4+col.
    logic [15:0] keys;

    int checks;
    int failures;
    int evt_cnt;

    typedef struct {
        string       name;
        logic [15:0] keys;
        logic [15:0] exp_matrix;
        logic        exp_evt;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs[6];

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .row_out       (row_out),
        .col_in        (col_in),
        .keypad_matrix (keypad_matrix),
        .key_event     (key_event),
        .key_code      (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a closed switch pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r*4+c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_event === 1'b1) evt_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Advance to the next COMMIT cycle (row_out all high).
    task automatic wait_commit();
        int n;
        n = 0;
        step();
        while (row_out !== 4'hF && n < 40) begin
            step();
            n++;
        end
        if (row_out !== 4'hF) begin
            checks++;
            failures++;
            $display("FAIL wait_commit actual=%0h required=f", row_out);
        end
    endtask

    function automatic logic [3:0] exp_row(input int k);
        int idx;
        idx = k % 21;
        if (idx < 5)  return 4'b1110;
        if (idx < 10) return 4'b1101;
        if (idx < 15) return 4'b1011;
        if (idx < 20) return 4'b0111;
        return 4'b1111;
    endfunction

    initial begin
        int ev0;
        int n;
        checks   = 0;
        failures = 0;
        evt_cnt  = 0;
        keys     = 16'h0000;
        rst_n    = 1'b0;

        //                 name          keys      matrix    evt  code
        vecs[0] = '{"press_c",     16'h0008, 16'h1000, 1'b1, 4'hC};
        vecs[1] = '{"release_c",   16'h0000, 16'h0000, 1'b0, 4'hC};
        vecs[2] = '{"press_0_b",   16'h6000, 16'h0801, 1'b1, 4'h0};
        vecs[3] = '{"release_0",   16'h4000, 16'h0800, 1'b0, 4'h0};
        vecs[4] = '{"press_7",     16'h4100, 16'h0880, 1'b1, 4'h7};
        vecs[5] = '{"swap_to_c",   16'h0008, 16'h1000, 1'b1, 4'hC};

        // Reset state and idle scan pattern.
        repeat (4) step();
        check("rst_row_out", 32'(row_out), 32'hF);
        check("rst_matrix", 32'(keypad_matrix), 32'h0);
        check("rst_event", 32'(key_event), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 42; k++) begin
            step();
            check($sformatf("idle_row_%0d", k), 32'(row_out), 32'(exp_row(k)));
        end
        check("idle_matrix", 32'(keypad_matrix), 32'h0);
        check("idle_events", 32'(evt_cnt), 32'h0);
        step();

        // Table-driven press / release scenarios (first two vectors).
        for (int i = 0; i < 2; i++) begin
            ev0  = evt_cnt;
            keys = vecs[i].keys;
            repeat (3) wait_commit();
            check({vecs[i].name, "_pre_matrix"}, 32'(keypad_matrix == vecs[i].exp_matrix), 32'h0);
            step();
            check({vecs[i].name, "_matrix"}, 32'(keypad_matrix), 32'(vecs[i].exp_matrix));
            check({vecs[i].name, "_event"}, 32'(key_event), 32'(vecs[i].exp_evt));
            check({vecs[i].name, "_code"}, 32'(key_code), 32'(vecs[i].exp_code));
            step();
            check({vecs[i].name, "_event_end"}, 32'(key_event), 32'h0);
            check({vecs[i].name, "_evt_count"}, 32'(evt_cnt - ev0), 32'(vecs[i].exp_evt));
        end

        // Bouncing key: r1c1 toggles every frame and must never commit.
        ev0 = evt_cnt;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            wait_commit();
            step();
            check($sformatf("bounce_matrix_%0d", i), 32'(keypad_matrix), 32'h0);
        end
        check("bounce_events", 32'(evt_cnt - ev0), 32'h0);

        // Remaining table vectors: dual press, release-only, add key, swap.
        for (int i = 2; i < 6; i++) begin
            ev0  = evt_cnt;
            keys = vecs[i].keys;
            repeat (3) wait_commit();
            check({vecs[i].name, "_pre_matrix"}, 32'(keypad_matrix == vecs[i].exp_matrix), 32'h0);
            step();
            check({vecs[i].name, "_matrix"}, 32'(keypad_matrix), 32'(vecs[i].exp_matrix));
            check({vecs[i].name, "_event"}, 32'(key_event), 32'(vecs[i].exp_evt));
            check({vecs[i].name, "_code"}, 32'(key_code), 32'(vecs[i].exp_code));
            step();
            check({vecs[i].name, "_event_end"}, 32'(key_event), 32'h0);
            check({vecs[i].name, "_evt_count"}, 32'(evt_cnt - ev0), 32'(vecs[i].exp_evt));
        end

        // Held matrix stays put over further identical frames.
        ev0 = evt_cnt;
        repeat (2) wait_commit();
        step();
        check("hold_matrix", 32'(keypad_matrix), 32'h1000);
        check("hold_events", 32'(evt_cnt - ev0), 32'h0);

        // Asynchronous reset in the middle of row 2 settle.
        n = 0;
        while (row_out !== 4'b1011 && n < 40) begin
            step();
            n++;
        end
        check("reach_row2", 32'(row_out), 32'b1011);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_row_out", 32'(row_out), 32'hF);
        check("midrst_matrix", 32'(keypad_matrix), 32'h0);
        check("midrst_event", 32'(key_event), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ev0 = evt_cnt;
        step();
        check("restart_row0", 32'(row_out), 32'b1110);
        repeat (3) wait_commit();
        check("recommit_pre", 32'(keypad_matrix), 32'h0);
        step();
        check("recommit_matrix", 32'(keypad_matrix), 32'h1000);
        check("recommit_event", 32'(key_event), 32'h1);
        check("recommit_code", 32'(key_code), 32'hC);
        step();
        check("recommit_evt_count", 32'(evt_cnt - ev0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
